// File: rtl/spi_crc_pkg.sv
// Shared CRC definitions for the SPI exe unit: FSM state type, default widths and
// the bit-serial CRC step used by both transmit and receive sides.
package spi_crc_pkg;

  typedef enum logic [1:0] {IDLE, DATA, CRC, DONE} crc_rx_state_t;

  localparam int CRC_WCODE_DEF = 4;
  localparam int CRC_WPOLY_DEF = 4;

  // One data bit of the carry-less multiply; result masked to the wcrc-bit CRC field.
  function automatic logic [31:0] crc_step(input logic [31:0] acc, input logic b,
                                           input logic [31:0] poly, input int unsigned wcrc);
    logic [31:0] mask;
    mask = (32'd1 << wcrc) - 32'd1;
    return ((acc << 1) ^ (b ? poly : 32'd0)) & mask;
  endfunction

endpackage

// File: rtl/crc_ser_acc.sv
// Bit-serial CRC accumulator: clears on i_clr, advances one data bit per i_en.
module crc_ser_acc
  import spi_crc_pkg::*;
#(
  parameter int WPOLY = CRC_WPOLY_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_bit,
  input  logic [WPOLY-1:0] i_poly,
  output logic [WPOLY-2:0] o_acc
);

  localparam int WCRC = WPOLY - 1;

  logic [WCRC-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (i_clr) begin
      acc_d = '0;
    end else if (i_en) begin
      acc_d = WCRC'(crc_step(32'(acc_q), i_bit, 32'(i_poly), WCRC));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign o_acc = acc_q;

endmodule

// File: rtl/crc4_rx_check.sv
// Receive-side CRC checker: deserialises data+CRC fields, recomputes the CRC and flags
// mismatches once per frame. Optional error counter enabled by CRC_ERR_CNT_EN.
module crc4_rx_check
  import spi_crc_pkg::*;
#(
  parameter int WCODE = CRC_WCODE_DEF,
  parameter int WPOLY = CRC_WPOLY_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WPOLY-1:0] i_poly,
  input  logic             i_start,
  input  logic             i_bit_valid,
  input  logic             i_bit,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_crc_err,
  output logic [WCODE-1:0] o_data,
  output logic [WPOLY-2:0] o_crc_rx,
  output logic [WPOLY-2:0] o_crc_calc,
`ifdef CRC_ERR_CNT_EN
  output logic [7:0]       o_err_cnt,
`endif
  output crc_rx_state_t    o_dbg_state
);

  localparam int WCRC = WPOLY - 1;
  localparam int CW   = $clog2(WCODE + WPOLY);

  // Bit handshake: a bit is consumed on any cycle with i_bit_valid=1 in DATA/CRC,
  // unless i_start is also high (start takes priority and the bit is dropped).
  crc_rx_state_t    state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WPOLY-1:0] poly_q, poly_d;
  logic [WCODE-1:0] data_sh_q, data_sh_d, data_q, data_d;
  logic [WCRC-1:0]  crc_sh_q, crc_sh_d, crc_rx_q, crc_rx_d, crc_calc_q, crc_calc_d;
  logic             err_q, err_d;
  logic [WCRC-1:0]  acc;
  logic             acc_clr, acc_en, take;

  assign take = i_bit_valid & ~i_start;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    poly_d     = poly_q;
    data_sh_d  = data_sh_q;
    crc_sh_d   = crc_sh_q;
    data_d     = data_q;
    crc_rx_d   = crc_rx_q;
    crc_calc_d = crc_calc_q;
    err_d      = err_q;
    acc_clr    = 1'b0;
    acc_en     = 1'b0;
    case (state_q)
      DATA: if (take) begin
        data_sh_d = WCODE'({data_sh_q, i_bit});
        acc_en    = 1'b1;
        if (cnt_q == CW'(WCODE - 1)) begin
          state_d = CRC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CRC: if (take) begin
        crc_sh_d = WCRC'({crc_sh_q, i_bit});
        if (cnt_q == CW'(WCRC - 1)) begin
          // Accumulator is final once the data field ends; capture the whole result here.
          state_d    = DONE;
          cnt_d      = '0;
          data_d     = data_sh_q;
          crc_rx_d   = crc_sh_d;
          crc_calc_d = acc;
          err_d      = (crc_sh_d != acc);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (i_start) begin
      state_d   = DATA;
      cnt_d     = '0;
      poly_d    = i_poly;
      data_sh_d = '0;
      crc_sh_d  = '0;
      acc_clr   = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      poly_q     <= '0;
      data_sh_q  <= '0;
      crc_sh_q   <= '0;
      data_q     <= '0;
      crc_rx_q   <= '0;
      crc_calc_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      poly_q     <= poly_d;
      data_sh_q  <= data_sh_d;
      crc_sh_q   <= crc_sh_d;
      data_q     <= data_d;
      crc_rx_q   <= crc_rx_d;
      crc_calc_q <= crc_calc_d;
      err_q      <= err_d;
    end
  end

  crc_ser_acc #(.WPOLY(WPOLY)) u_acc (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (acc_clr),
    .i_en    (acc_en),
    .i_bit   (i_bit),
    .i_poly  (poly_q),
    .o_acc   (acc)
  );

`ifdef CRC_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_cnt_q <= 8'h00;
    end else if (state_q == DONE && err_q && err_cnt_q != 8'hFF) begin
      err_cnt_q <= err_cnt_q + 8'h01;
    end
  end

  assign o_err_cnt = err_cnt_q;
`endif

  assign o_busy      = (state_q == DATA) || (state_q == CRC);
  assign o_done      = (state_q == DONE);
  assign o_crc_err   = o_done & err_q;
  assign o_data      = data_q;
  assign o_crc_rx    = crc_rx_q;
  assign o_crc_calc  = crc_calc_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_crc4_rx_check.sv
// Directed bench for crc4_rx_check: driver tasks push expected frame results into a
// queue; a monitor pops and compares on every o_done.
module tb_crc4_rx_check;
  import spi_crc_pkg::*;

  localparam int W = 11;  // {err, data[3:0], crc_rx[2:0], crc_calc[2:0]}

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    i_poly = '0;
  logic          i_start = 1'b0;
  logic          i_bit_valid = 1'b0;
  logic          i_bit = 1'b0;
  logic          o_busy, o_done, o_crc_err;
  logic [3:0]    o_data;
  logic [2:0]    o_crc_rx, o_crc_calc;
  crc_rx_state_t o_dbg_state;
`ifdef CRC_ERR_CNT_EN
  logic [7:0]    o_err_cnt;
`endif

  always #5 clk = ~clk;

  crc4_rx_check dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_poly      (i_poly),
    .i_start     (i_start),
    .i_bit_valid (i_bit_valid),
    .i_bit       (i_bit),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_crc_err   (o_crc_err),
    .o_data      (o_data),
    .o_crc_rx    (o_crc_rx),
    .o_crc_calc  (o_crc_calc),
`ifdef CRC_ERR_CNT_EN
    .o_err_cnt   (o_err_cnt),
`endif
    .o_dbg_state (o_dbg_state)
  );

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int done_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n === 1'b1 && o_done === 1'b1) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done actual data=%0h crc_rx=%0h", o_data, o_crc_rx);
      end else begin
        check("frame", 32'({o_crc_err, o_data, o_crc_rx, o_crc_calc}), 32'(exp_q.pop_front()));
      end
    end
  end

  typedef struct {
    logic [3:0] data;
    logic [2:0] crc;
    logic [3:0] poly;
    logic [2:0] calc;
    logic       err;
  } vec_t;

  // Hand-computed: calc = low 3 bits of carry-less data*poly
  vec_t vecs[6] = '{
    '{4'b1011, 3'b101, 4'b1011, 3'b101, 1'b0},
    '{4'b1011, 3'b100, 4'b1011, 3'b101, 1'b1},
    '{4'b1111, 3'b011, 4'b1101, 3'b011, 1'b0},
    '{4'b0000, 3'b000, 4'b1011, 3'b000, 1'b0},
    '{4'b1000, 3'b000, 4'b0111, 3'b000, 1'b0},
    '{4'b0101, 3'b101, 4'b1001, 3'b101, 1'b0}
  };

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input vec_t v);
    exp_q.push_back({v.err, v.data, v.crc, v.calc});
  endtask

  // Start pulse; optionally with a simultaneous valid bit that must be dropped.
  task automatic start_frame(input logic [3:0] poly, input logic with_bit);
    i_start     = 1'b1;
    i_poly      = poly;
    i_bit_valid = with_bit;
    i_bit       = 1'b1;
    tick();
    i_start     = 1'b0;
    i_bit_valid = 1'b0;
    i_poly      = ~poly;
  endtask

  task automatic send_bits(input logic [6:0] frame, input int n, input int gap,
                           input logic chk_lat);
    for (int i = 0; i < n; i++) begin
      i_bit       = frame[6-i];
      i_bit_valid = 1'b1;
      tick();
      i_bit_valid = 1'b0;
      if (chk_lat && i == n - 1) check("done_latency", 32'(o_done), 32'd1);
      repeat (gap) tick();
    end
  endtask

  task automatic run_vec(input vec_t v, input int gap);
    push_exp(v);
    start_frame(v.poly, 1'b0);
    send_bits({v.data, v.crc}, 7, gap, 1'b1);
    tick();
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},   32'(o_busy), 32'd0);
    check({tag, "_done"},   32'(o_done), 32'd0);
    check({tag, "_err"},    32'(o_crc_err), 32'd0);
    check({tag, "_data"},   32'(o_data), 32'd0);
    check({tag, "_crc_rx"}, 32'(o_crc_rx), 32'd0);
    check({tag, "_calc"},   32'(o_crc_calc), 32'd0);
    check({tag, "_state"},  32'(o_dbg_state), 32'(IDLE));
`ifdef CRC_ERR_CNT_EN
    check({tag, "_err_cnt"}, 32'(o_err_cnt), 32'd0);
`endif
  endtask

  initial begin
    int d0;
    vec_t v;
    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Valid bits in IDLE are ignored
    i_bit_valid = 1'b1;
    i_bit       = 1'b1;
    repeat (3) tick();
    i_bit_valid = 1'b0;
    check("idle_busy", 32'(o_busy), 32'd0);
    check("idle_state", 32'(o_dbg_state), 32'(IDLE));

    foreach (vecs[k]) run_vec(vecs[k], 0);
`ifdef CRC_ERR_CNT_EN
    check("err_cnt_one", 32'(o_err_cnt), 32'd1);
`endif

    // Gapped frame, start coincident with a valid bit that must be discarded
    v = '{4'b0001, 3'b011, 4'b1011, 3'b011, 1'b0};
    push_exp(v);
    start_frame(v.poly, 1'b1);
    send_bits({v.data, v.crc}, 7, 3, 1'b1);
    tick();

    // Abort after two data bits, then a full frame: exactly one o_done
    d0 = done_seen;
    start_frame(4'b1011, 1'b0);
    send_bits(7'b1100_000, 2, 0, 1'b0);
    check("abort_busy", 32'(o_busy), 32'd1);
    check("abort_held_data", 32'(o_data), 32'h1);
    v = '{4'b0110, 3'b010, 4'b1011, 3'b010, 1'b0};
    push_exp(v);
    start_frame(v.poly, 1'b0);
    send_bits({v.data, v.crc}, 7, 0, 1'b1);
    tick();
    tick();
    check("abort_one_done", 32'(done_seen - d0), 32'd1);

    // Start during DONE: the pulse completes and the next frame begins
    d0 = done_seen;
    push_exp(vecs[0]);
    start_frame(vecs[0].poly, 1'b0);
    send_bits({vecs[0].data, vecs[0].crc}, 7, 0, 1'b1);
    v = '{4'b0001, 3'b011, 4'b1011, 3'b011, 1'b0};
    push_exp(v);
    start_frame(v.poly, 1'b0);
    check("start_in_done_busy", 32'(o_busy), 32'd1);
    send_bits({v.data, v.crc}, 7, 0, 1'b1);
    tick();
    tick();
    check("start_in_done_count", 32'(done_seen - d0), 32'd2);
    check("start_in_done_data", 32'(o_data), 32'h1);

    // Reset mid-frame after the 5th bit
    d0 = done_seen;
    start_frame(4'b1011, 1'b0);
    send_bits(7'b1011_101, 5, 0, 1'b0);
    rst_n = 1'b0;
    #2;
    check_all_zero("midrst");
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst_no_done", 32'(done_seen - d0), 32'd0);
    run_vec(vecs[0], 0);

`ifdef CRC_ERR_CNT_EN
    for (int k = 0; k < 300; k++) run_vec(vecs[1], 0);
    check("err_cnt_sat", 32'(o_err_cnt), 32'hFF);
    run_vec(vecs[1], 1);
    check("err_cnt_stays", 32'(o_err_cnt), 32'hFF);
`endif

    repeat (3) tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
